// File: rtl/wavetable_voices_if.sv
// wavetable_voices_if: control, table-ROM and sample bus of the wavetable voice block
interface wavetable_voices_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W = 12,
    parameter int IDX_W = 8,
    parameter int SAMPLE_W = 7,
    parameter int VOL_W = 4
);
    logic [NUM_CH*DIV_W-1:0] divider;
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] retrigger;
    logic [NUM_CH*VOL_W-1:0] volume;
    logic [IDX_W-1:0] rom_addr;
    logic [SAMPLE_W-1:0] rom_data;
    logic [NUM_CH*SAMPLE_W-1:0] sample;
    logic [NUM_CH-1:0] sample_valid;
    logic [NUM_CH-1:0] wrap;
    modport master (
        output divider, enable, retrigger, volume, rom_data,
        input rom_addr, sample, sample_valid, wrap
    );
    modport slave (
        input divider, enable, retrigger, volume, rom_data,
        output rom_addr, sample, sample_valid, wrap
    );
endinterface

// File: rtl/wavetable_voices.sv
// wavetable_voices: N-voice wavetable oscillator sharing one table ROM round-robin
module wavetable_voices #(
    parameter int NUM_CH = 4,
    parameter int DIV_W = 12,
    parameter int IDX_W = 8,
    parameter int SAMPLE_W = 7,
    parameter int VOL_W = 4
) (
    input logic clk,
    input logic rst_n,
    wavetable_voices_if.slave bus
);
    localparam int SLOT_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = SAMPLE_W + VOL_W + 1;
    logic [DIV_W-1:0] count [NUM_CH];
    logic [IDX_W-1:0] idx [NUM_CH];
    logic [SLOT_W-1:0] slot, p_slot;
    logic p_valid, p_en;
    logic [SAMPLE_W-1:0] p_data, scaled;
    logic [VOL_W-1:0] p_vol;
    assign bus.rom_addr = idx[slot];
    // volume v scales by (v+1)/2^VOL_W, so all-ones is unity gain
    assign scaled = SAMPLE_W'((PROD_W'(p_data) * (PROD_W'(p_vol) + PROD_W'(1))) >> VOL_W);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                count[c] <= '0;
                idx[c] <= '0;
            end
            bus.wrap <= '0;
        end else begin
            bus.wrap <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.retrigger[c]) begin
                    count[c] <= bus.divider[c*DIV_W +: DIV_W];
                    idx[c] <= '0;
                end else if (bus.enable[c]) begin
                    if (count[c] == '0) begin
                        count[c] <= bus.divider[c*DIV_W +: DIV_W];
                        idx[c] <= idx[c] + IDX_W'(1);
                        bus.wrap[c] <= &idx[c];
                    end else begin
                        count[c] <= count[c] - DIV_W'(1);
                    end
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot <= '0;
            p_valid <= 1'b0;
            bus.sample <= '0;
            bus.sample_valid <= '0;
        end else begin
            slot <= (slot == SLOT_W'(NUM_CH - 1)) ? '0 : slot + SLOT_W'(1);
            p_valid <= 1'b1;
            p_slot <= slot;
            p_data <= bus.rom_data;
            p_vol <= bus.volume[slot*VOL_W +: VOL_W];
            p_en <= bus.enable[slot];
            bus.sample_valid <= p_valid ? NUM_CH'(1) << p_slot : '0;
            if (p_valid)
                bus.sample[p_slot*SAMPLE_W +: SAMPLE_W] <= p_en ? scaled : '0;
        end
    end
endmodule

// File: tb/tb_wavetable_voices.sv
// tb_wavetable_voices: randomized, reference-model-checked bench for wavetable_voices
module tb_wavetable_voices;
    localparam int N = 4, DW = 12, IW = 8, SW = 7, VW = 4;
    typedef struct { int slot; int data; int vol; bit en; } ent_t;
    logic clk = 1'b0, rst_n = 1'b0, rst3_n = 1'b0;
    int n_tests = 0, n_fail = 0;
    int m_idx[N], m_cnt[N], m_sample[N], m_slot;
    logic [N-1:0] m_valid, m_wrap;
    ent_t pipe[$];

    wavetable_voices_if #(.NUM_CH(N), .DIV_W(DW), .IDX_W(IW), .SAMPLE_W(SW), .VOL_W(VW)) bus ();
    wavetable_voices_if #(.NUM_CH(3), .DIV_W(DW), .IDX_W(6), .SAMPLE_W(SW), .VOL_W(VW)) bus3 ();
    wavetable_voices #(.NUM_CH(N), .DIV_W(DW), .IDX_W(IW), .SAMPLE_W(SW), .VOL_W(VW))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    wavetable_voices #(.NUM_CH(3), .DIV_W(DW), .IDX_W(6), .SAMPLE_W(SW), .VOL_W(VW))
        dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3));

    function automatic int rom_f(int a);
        return (a * 37 + 119) % 128;
    endfunction
    assign bus.rom_data = SW'(rom_f(int'(bus.rom_addr)));
    assign bus3.rom_data = SW'(int'(bus3.rom_addr) + 3);

    always #5 clk = ~clk;

    // advance one clock, update the reference model at the edge, return on the falling edge
    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                m_idx[c] = 0;
                m_cnt[c] = 0;
                m_sample[c] = 0;
            end
            m_slot = 0;
            m_valid = '0;
            m_wrap = '0;
            pipe.delete();
        end else begin
            m_valid = '0;
            m_wrap = '0;
            if (pipe.size() != 0) begin
                e = pipe.pop_front();
                m_valid[e.slot] = 1'b1;
                m_sample[e.slot] = e.en ? (e.data * (e.vol + 1)) / 16 : 0;
            end
            e.slot = m_slot;
            e.data = rom_f(m_idx[m_slot]);
            e.vol = int'(bus.volume[m_slot*VW +: VW]);
            e.en = bus.enable[m_slot];
            pipe.push_back(e);
            for (int c = 0; c < N; c++) begin
                if (bus.retrigger[c]) begin
                    m_cnt[c] = int'(bus.divider[c*DW +: DW]);
                    m_idx[c] = 0;
                end else if (bus.enable[c]) begin
                    if (m_cnt[c] == 0) begin
                        m_cnt[c] = int'(bus.divider[c*DW +: DW]);
                        if (m_idx[c] == 255) m_wrap[c] = 1'b1;
                        m_idx[c] = (m_idx[c] + 1) % 256;
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end
                end
            end
            m_slot = (m_slot + 1) % N;
        end
        @(negedge clk);
    endtask

    task automatic drive_random(int dmax);
        for (int c = 0; c < N; c++) begin
            bus.divider[c*DW +: DW] = DW'($urandom_range(0, dmax));
            bus.enable[c] = ($urandom_range(0, 9) != 0);
            bus.retrigger[c] = ($urandom_range(0, 19) == 0);
            bus.volume[c*VW +: VW] = VW'($urandom_range(0, 15));
        end
    endtask

    task automatic test_reset();
        logic [N-1:0] exp_v;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_random(4095);
            tick();
            n_tests++;
            if (bus.sample !== '0) begin n_fail++; $display("FAIL reset_sample: got %h expected 0", bus.sample); end
            n_tests++;
            if (bus.sample_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.sample_valid); end
            n_tests++;
            if (bus.wrap !== '0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", bus.wrap); end
            n_tests++;
            if (bus.rom_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.rom_addr); end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_v = (k >= 2) ? N'(1 << ((k - 2) % N)) : '0;
            n_tests++;
            if (bus.sample_valid !== exp_v) begin n_fail++; $display("FAIL valid_walk k=%0d: got %b expected %b", k, bus.sample_valid, exp_v); end
        end
    endtask

    task automatic test_step_rate();
        int wraps;
        wraps = 0;
        bus.divider = '0;
        bus.divider[DW-1:0] = DW'(3);
        bus.enable = N'(1);
        bus.retrigger = N'(1);
        bus.volume = '1;
        tick();
        bus.retrigger = '0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (m_slot == 0) begin
                n_tests++;
                if (bus.rom_addr !== IW'((k / 4) % 256)) begin n_fail++; $display("FAIL step_idx k=%0d: got %0d expected %0d", k, bus.rom_addr, (k / 4) % 256); end
            end
            if (bus.wrap[0]) begin
                wraps++;
                n_tests++;
                if (k != 1024) begin n_fail++; $display("FAIL wrap_time: got k=%0d expected k=1024", k); end
            end
            n_tests++;
            if (bus.wrap !== m_wrap) begin n_fail++; $display("FAIL step_wrap k=%0d: got %b expected %b", k, bus.wrap, m_wrap); end
        end
        n_tests++;
        if (wraps != 1) begin n_fail++; $display("FAIL wrap_count: got %0d expected 1", wraps); end
    endtask

    task automatic test_volume();
        int exp_s[3] = '{119, 59, 7};
        int pulses;
        pulses = 0;
        bus.retrigger = '1;
        bus.enable = '1;
        bus.volume = {VW'($urandom_range(0, 15)), VW'(0), VW'(7), VW'(15)};
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (bus.rom_addr !== '0) begin n_fail++; $display("FAIL vol_addr: got %0d expected 0", bus.rom_addr); end
            for (int c = 0; c < 3; c++) begin
                if (bus.sample_valid[c]) begin
                    n_tests++;
                    if (bus.sample[c*SW +: SW] !== SW'(exp_s[c])) begin n_fail++; $display("FAIL vol_ch%0d: got %0d expected %0d", c, bus.sample[c*SW +: SW], exp_s[c]); end
                end
            end
            if (bus.sample_valid[3]) begin
                n_tests++;
                if (bus.sample[3*SW +: SW] !== SW'(m_sample[3])) begin n_fail++; $display("FAIL vol_ch3: got %0d expected %0d", bus.sample[3*SW +: SW], m_sample[3]); end
            end
            if (bus.sample_valid[0]) pulses++;
        end
        n_tests++;
        if (pulses != 2) begin n_fail++; $display("FAIL vol_pulses: got %0d expected 2", pulses); end
        bus.retrigger = '0;
    endtask

    task automatic test_enable();
        int frozen, pulses;
        pulses = 0;
        for (int c = 0; c < N; c++) bus.divider[c*DW +: DW] = DW'($urandom_range(0, 3));
        bus.enable = '1;
        bus.retrigger = '0;
        bus.volume = '1;
        for (int i = 0; i < 40; i++) tick();
        bus.enable[2] = 1'b0;
        frozen = m_idx[2];
        for (int j = 0; j < 12; j++) begin
            tick();
            if (m_slot == 2) begin
                n_tests++;
                if (bus.rom_addr !== IW'(frozen)) begin n_fail++; $display("FAIL frozen_idx: got %0d expected %0d", bus.rom_addr, frozen); end
            end
            if (bus.sample_valid[2]) begin
                pulses++;
                if (j >= 1) begin
                    n_tests++;
                    if (bus.sample[2*SW +: SW] !== '0) begin n_fail++; $display("FAIL silent_ch2: got %0d expected 0", bus.sample[2*SW +: SW]); end
                end
            end
        end
        n_tests++;
        if (pulses != 3) begin n_fail++; $display("FAIL silent_pulses: got %0d expected 3", pulses); end
        bus.enable[2] = 1'b1;
        for (int j = 0; j < 24; j++) begin
            tick();
            if (m_slot == 2) begin
                n_tests++;
                if (bus.rom_addr !== IW'(m_idx[2])) begin n_fail++; $display("FAIL resume_idx: got %0d expected %0d", bus.rom_addr, m_idx[2]); end
            end
            if (bus.sample_valid[2]) begin
                n_tests++;
                if (bus.sample[2*SW +: SW] !== SW'(m_sample[2])) begin n_fail++; $display("FAIL resume_sample: got %0d expected %0d", bus.sample[2*SW +: SW], m_sample[2]); end
            end
        end
    endtask

    task automatic test_retrigger();
        bus.divider = '0;
        bus.divider[DW +: DW] = DW'(2);
        bus.enable = N'(2);
        bus.retrigger = N'(2);
        tick();
        bus.retrigger = '0;
        for (int k = 1; k <= 602; k++) begin
            tick();
            if (m_slot == 1) begin
                n_tests++;
                if (bus.rom_addr !== IW'(k / 3)) begin n_fail++; $display("FAIL pre_retrig_idx k=%0d: got %0d expected %0d", k, bus.rom_addr, k / 3); end
            end
        end
        bus.retrigger = N'(2);
        tick();
        bus.retrigger = '0;
        for (int j = 0; j < 12; j++) begin
            n_tests++;
            if (bus.wrap !== '0) begin n_fail++; $display("FAIL retrig_wrap j=%0d: got %b expected 0", j, bus.wrap); end
            if (m_slot == 1) begin
                n_tests++;
                if (bus.rom_addr !== IW'(j / 3)) begin n_fail++; $display("FAIL retrig_idx j=%0d: got %0d expected %0d", j, bus.rom_addr, j / 3); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_random(3);
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
            n_tests++;
            if (bus.rom_addr !== IW'(m_idx[m_slot])) begin n_fail++; $display("FAIL rnd_addr i=%0d: got %0d expected %0d", i, bus.rom_addr, m_idx[m_slot]); end
            n_tests++;
            if (bus.sample_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid i=%0d: got %b expected %b", i, bus.sample_valid, m_valid); end
            n_tests++;
            if (bus.wrap !== m_wrap) begin n_fail++; $display("FAIL rnd_wrap i=%0d: got %b expected %b", i, bus.wrap, m_wrap); end
            for (int c = 0; c < N; c++) begin
                n_tests++;
                if (bus.sample[c*SW +: SW] !== SW'(m_sample[c])) begin n_fail++; $display("FAIL rnd_sample ch%0d i=%0d: got %0d expected %0d", c, i, bus.sample[c*SW +: SW], m_sample[c]); end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_small_build();
        logic [2:0] exp_v, exp_w;
        rst3_n = 1'b0;
        tick();
        n_tests++;
        if (bus3.sample_valid !== '0 || bus3.wrap !== '0 || bus3.sample !== '0) begin n_fail++; $display("FAIL small_reset: got valid=%b wrap=%b sample=%h expected 0", bus3.sample_valid, bus3.wrap, bus3.sample); end
        rst3_n = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            exp_v = (k >= 2) ? 3'(1 << ((k - 2) % 3)) : '0;
            exp_w = (k == 64) ? 3'b111 : 3'b000;
            n_tests++;
            if (bus3.sample_valid !== exp_v) begin n_fail++; $display("FAIL small_valid k=%0d: got %b expected %b", k, bus3.sample_valid, exp_v); end
            n_tests++;
            if (bus3.wrap !== exp_w) begin n_fail++; $display("FAIL small_wrap k=%0d: got %b expected %b", k, bus3.wrap, exp_w); end
            n_tests++;
            if (bus3.rom_addr !== 6'(k % 64)) begin n_fail++; $display("FAIL small_addr k=%0d: got %0d expected %0d", k, bus3.rom_addr, k % 64); end
            for (int c = 0; c < 3; c++) begin
                if (bus3.sample_valid[c]) begin
                    n_tests++;
                    if (bus3.sample[c*SW +: SW] !== SW'((k - 2) % 64 + 3)) begin n_fail++; $display("FAIL small_sample ch%0d k=%0d: got %0d expected %0d", c, k, bus3.sample[c*SW +: SW], (k - 2) % 64 + 3); end
                end
            end
        end
        rst3_n = 1'b0;
        tick();
        n_tests++;
        if (bus3.sample_valid !== '0 || bus3.wrap !== '0 || bus3.sample !== '0 || bus3.rom_addr !== '0) begin n_fail++; $display("FAIL small_midreset: got valid=%b wrap=%b sample=%h addr=%0d expected 0", bus3.sample_valid, bus3.wrap, bus3.sample, bus3.rom_addr); end
        rst3_n = 1'b1;
        tick();
        n_tests++;
        if (bus3.sample_valid !== '0) begin n_fail++; $display("FAIL small_stale: got %b expected 000", bus3.sample_valid); end
        tick();
        n_tests++;
        if (bus3.sample_valid !== 3'b001) begin n_fail++; $display("FAIL small_restart: got %b expected 001", bus3.sample_valid); end
    endtask

    initial begin
        bus.divider = '0;
        bus.enable = '0;
        bus.retrigger = '0;
        bus.volume = '0;
        bus3.divider = '0;
        bus3.enable = '1;
        bus3.retrigger = '0;
        bus3.volume = '1;
        test_reset();
        test_step_rate();
        test_volume();
        test_enable();
        test_retrigger();
        test_random();
        test_small_build();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
